note_frame_controller: RTL and testbench
========================================

Name: note_frame_controller

Overview:
- Control FSM directly upstream of the note-grid datapath; generates every control strobe and counter that datapath consumes.
- Sequences three phases per song:
  - Draw the 240x180 default background from the default image memory.
  - On each timing tick, shift the three note lanes one position.
  - Redraw the twelve 60x60 note boxes.
- Delays a pixel-valid strobe to match datapath latency; the strobe drives the VGA adapter plot input.

Parameters:
GRID_W, 240, default-image width in pixels (x index 0..GRID_W-1)
GRID_H, 180, default-image height in pixels (y index 0..GRID_H-1)
BOX_SIZE, 60, box edge length in pixels
NUM_BOXES, 12, boxes redrawn per song step (box indices 1..NUM_BOXES)
TICK_CYCLES, 12500000, clock cycles from entering WAIT to the SHIFT pulse
SONG_STEPS, 112, number of shifts before the song ends
PIPE_DEPTH, 3, datapath latency from control strobe to registered VGA outputs

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low (0 = reset asserted)
start  input  1  level; sampled only in IDLE
shiftSong  output  1  one-cycle pulse, advances note lanes
writeToScreen  output  1  selects box-pixel path on VGA output regs
loadStartAddress  output  1  high in BOX_SETUP
loadX  output  1  high in BOX_DRAW
loadY  output  1  high in BOX_DRAW (identical to loadX)
loadDefault  output  1  high in DEFAULT
writeDefault  output  1  high in DEFAULT and DEFAULT_FLUSH
songDone  output  1  one-cycle pulse at song end
gridCounter  output  16  {x[7:0], y[7:0]} default-image pixel index
boxCounter  output  4  current box, 0 when no box is active
pixelCount  output  15  {x[7:0], y[6:0]} pixel offset within a box
vgaPlot  output  1  pixel-valid strobe delayed by PIPE_DEPTH
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset:
  - State goes to IDLE immediately.
  - All outputs, counters, the tick counter, the step counter and the vgaPlot delay line clear to 0.
  - Reset asserted mid-operation aborts with no completion pulse.
- IDLE:
  - All strobes are 0.
  - start=1 -> DEFAULT with gridCounter=0.
- DEFAULT:
  - loadDefault=1, writeDefault=1.
  - y increments each cycle; at y=GRID_H-1, y wraps to 0 and x increments.
  - At x=GRID_W-1, y=GRID_H-1 -> DEFAULT_FLUSH.
  - Duration is exactly GRID_W*GRID_H cycles.
- DEFAULT_FLUSH:
  - PIPE_DEPTH cycles with writeDefault=1 and loadDefault=0; gridCounter holds its last value.
  - Then -> WAIT, with gridCounter cleared.
- WAIT:
  - Tick counter counts 0..TICK_CYCLES-1.
  - At the terminal count -> SHIFT.
- SHIFT:
  - shiftSong=1 for exactly one cycle; step counter increments.
  - If the new step count equals SONG_STEPS -> DONE; else -> BOX_SETUP with boxCounter=1.
- BOX_SETUP:
  - One cycle, loadStartAddress=1, pixelCount=0.
  - This cycle lets the datapath register the box start address and colour select.
  - Then -> BOX_DRAW.
- BOX_DRAW:
  - loadX=loadY=writeToScreen=1.
  - pixelCount y increments each cycle; at y=BOX_SIZE-1, y wraps to 0 and x increments.
  - Last pixel (x=y=BOX_SIZE-1):
    - If boxCounter<NUM_BOXES: boxCounter increments -> BOX_SETUP.
    - Else -> BOX_FLUSH.
- BOX_FLUSH:
  - PIPE_DEPTH cycles with writeToScreen=1, loadX=loadY=0; boxCounter and pixelCount hold.
  - Then boxCounter=0, pixelCount=0 -> WAIT.
- DONE:
  - songDone=1 for one cycle; step counter clears -> IDLE.
  - start still high in IDLE begins a new song on the next cycle.
- writeDefault and writeToScreen are never high in the same cycle.
- vgaPlot(t) = (loadDefault | loadX)(t-PIPE_DEPTH), implemented as a shift register.
  - vgaPlot count per DEFAULT phase = GRID_W*GRID_H.
  - vgaPlot count per box redraw = NUM_BOXES*BOX_SIZE^2.
- Counter widths:
  - Unused upper bits of gridCounter x/y fields and of pixelCount x/y fields are 0.
  - The tick counter is 24 bits.
  - The step counter is 7 bits minimum; sized by $clog2(SONG_STEPS+1).
- start is ignored outside IDLE.
- A tick is never dropped: WAIT is entered only after a redraw completes, so the effective step period is TICK_CYCLES plus redraw time.

Test Plan:
- Reset/idle: hold reset=0 for 5 cycles, release with start=0 -> all outputs 0, busy=0 for 20 cycles.
- Default sweep (GRID_W=4, GRID_H=3, PIPE_DEPTH=3): pulse start -> 12 cycles loadDefault=1 with gridCounter 0x0000,0x0001,0x0002,0x0100,...,0x0302; then 3 cycles writeDefault only; exactly 12 vgaPlot pulses, the first 3 cycles after the first loadDefault.
- Tick/shift (TICK_CYCLES=5): after DEFAULT_FLUSH -> shiftSong high exactly one cycle, 5 cycles after WAIT entry.
- Box sweep (BOX_SIZE=2, NUM_BOXES=12):
  - After shift, boxCounter steps 1..12.
  - Each box gets one loadStartAddress cycle, then 4 draw cycles with pixelCount 0x000,0x001,0x080,0x081.
  - 48 vgaPlot pulses total; boxCounter returns to 0.
- Song end (SONG_STEPS=2, TICK_CYCLES=3): start -> second shiftSong is followed next cycle by a one-cycle songDone and no box redraw; busy falls; start held high restarts DEFAULT.
- Async reset mid-BOX_DRAW (boxCounter=5): drive reset=0 between clock edges -> outputs clear before the next edge, no songDone; after release, IDLE.

Source files
------------

// File: rtl/note_frame_controller.sv
// Control FSM for the note-grid datapath: background sweep, timed lane shifts and
// box redraws, with a pixel-valid strobe delayed to match datapath latency.
module note_frame_controller #(
    parameter int unsigned GRID_W      = 240,
    parameter int unsigned GRID_H      = 180,
    parameter int unsigned BOX_SIZE    = 60,
    parameter int unsigned NUM_BOXES   = 12,
    parameter int unsigned TICK_CYCLES = 12500000,
    parameter int unsigned SONG_STEPS  = 112,
    parameter int unsigned PIPE_DEPTH  = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        shiftSong,
    output logic        writeToScreen,
    output logic        loadStartAddress,
    output logic        loadX,
    output logic        loadY,
    output logic        loadDefault,
    output logic        writeDefault,
    output logic        songDone,
    output logic [15:0] gridCounter,
    output logic [3:0]  boxCounter,
    output logic [14:0] pixelCount,
    output logic        vgaPlot,
    output logic        busy
);

    localparam int unsigned TICK_W     = 24;
    localparam int unsigned STEP_W_RAW = $clog2(SONG_STEPS + 1);
    localparam int unsigned STEP_W     = (STEP_W_RAW > 7) ? STEP_W_RAW : 7;
    localparam int unsigned FLUSH_W    = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_DEFAULT, S_DEFAULT_FLUSH, S_WAIT, S_SHIFT,
        S_BOX_SETUP, S_BOX_DRAW, S_BOX_FLUSH, S_DONE
    } state_t;

    state_t               state, nextState;
    logic [7:0]           gridX, gridY, nextGridX, nextGridY;
    logic [7:0]           pixX, nextPixX;
    logic [6:0]           pixY, nextPixY;
    logic [3:0]           boxCount, nextBox;
    logic [TICK_W-1:0]    tickCount, nextTick;
    logic [STEP_W-1:0]    stepCount, nextStep;
    logic [FLUSH_W-1:0]   flushCount, nextFlush;
    logic [PIPE_DEPTH-1:0] plotPipe;

    // Next-state, counter updates, and strobes decoded from the next state
    always_comb begin
        nextState  = state;
        nextGridX  = gridX;
        nextGridY  = gridY;
        nextPixX   = pixX;
        nextPixY   = pixY;
        nextBox    = boxCount;
        nextTick   = tickCount;
        nextStep   = stepCount;
        nextFlush  = flushCount;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    nextState = S_DEFAULT;
                    nextGridX = '0;
                    nextGridY = '0;
                end
            end
            S_DEFAULT: begin
                if (gridY == 8'(GRID_H - 1)) begin
                    if (gridX == 8'(GRID_W - 1)) begin
                        nextState = S_DEFAULT_FLUSH;
                        nextFlush = '0;
                    end else begin
                        nextGridY = '0;
                        nextGridX = gridX + 8'd1;
                    end
                end else begin
                    nextGridY = gridY + 8'd1;
                end
            end
            S_DEFAULT_FLUSH: begin
                if (flushCount == FLUSH_W'(PIPE_DEPTH - 1)) begin
                    nextState = S_WAIT;
                    nextGridX = '0;
                    nextGridY = '0;
                    nextTick  = '0;
                end else begin
                    nextFlush = flushCount + FLUSH_W'(1);
                end
            end
            S_WAIT: begin
                if (tickCount == TICK_W'(TICK_CYCLES - 1)) begin
                    nextState = S_SHIFT;
                end else begin
                    nextTick = tickCount + TICK_W'(1);
                end
            end
            S_SHIFT: begin
                nextStep = stepCount + STEP_W'(1);
                if (nextStep == STEP_W'(SONG_STEPS)) begin
                    nextState = S_DONE;
                end else begin
                    nextState = S_BOX_SETUP;
                    nextBox   = 4'd1;
                    nextPixX  = '0;
                    nextPixY  = '0;
                end
            end
            S_BOX_SETUP: begin
                nextState = S_BOX_DRAW;
            end
            S_BOX_DRAW: begin
                if (pixY == 7'(BOX_SIZE - 1)) begin
                    if (pixX == 8'(BOX_SIZE - 1)) begin
                        if (boxCount < 4'(NUM_BOXES)) begin
                            nextState = S_BOX_SETUP;
                            nextBox   = boxCount + 4'd1;
                            nextPixX  = '0;
                            nextPixY  = '0;
                        end else begin
                            nextState = S_BOX_FLUSH;
                            nextFlush = '0;
                        end
                    end else begin
                        nextPixY = '0;
                        nextPixX = pixX + 8'd1;
                    end
                end else begin
                    nextPixY = pixY + 7'd1;
                end
            end
            S_BOX_FLUSH: begin
                if (flushCount == FLUSH_W'(PIPE_DEPTH - 1)) begin
                    nextState = S_WAIT;
                    nextBox   = '0;
                    nextPixX  = '0;
                    nextPixY  = '0;
                    nextTick  = '0;
                end else begin
                    nextFlush = flushCount + FLUSH_W'(1);
                end
            end
            S_DONE: begin
                nextState = S_IDLE;
                nextStep  = '0;
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            gridX            <= '0;
            gridY            <= '0;
            pixX             <= '0;
            pixY             <= '0;
            boxCount         <= '0;
            tickCount        <= '0;
            stepCount        <= '0;
            flushCount       <= '0;
            plotPipe         <= '0;
            shiftSong        <= 1'b0;
            writeToScreen    <= 1'b0;
            loadStartAddress <= 1'b0;
            loadX            <= 1'b0;
            loadY            <= 1'b0;
            loadDefault      <= 1'b0;
            writeDefault     <= 1'b0;
            songDone         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= nextState;
            gridX            <= nextGridX;
            gridY            <= nextGridY;
            pixX             <= nextPixX;
            pixY             <= nextPixY;
            boxCount         <= nextBox;
            tickCount        <= nextTick;
            stepCount        <= nextStep;
            flushCount       <= nextFlush;
            // Pixel-valid delay line tracks the datapath pipeline
            plotPipe         <= (plotPipe << 1) | PIPE_DEPTH'(loadDefault | loadX);
            shiftSong        <= (nextState == S_SHIFT);
            writeToScreen    <= (nextState == S_BOX_DRAW) || (nextState == S_BOX_FLUSH);
            loadStartAddress <= (nextState == S_BOX_SETUP);
            loadX            <= (nextState == S_BOX_DRAW);
            loadY            <= (nextState == S_BOX_DRAW);
            loadDefault      <= (nextState == S_DEFAULT);
            writeDefault     <= (nextState == S_DEFAULT) || (nextState == S_DEFAULT_FLUSH);
            songDone         <= (nextState == S_DONE);
            busy             <= (nextState != S_IDLE);
        end
    end

    assign gridCounter = {gridX, gridY};
    assign pixelCount  = {pixX, pixY};
    assign boxCounter  = boxCount;
    assign vgaPlot     = plotPipe[PIPE_DEPTH-1];

endmodule

// File: tb/tb_note_frame_controller.sv
// Self-checking bench for note_frame_controller: expected per-cycle output records
// are generated from the phase structure and compared cycle by cycle.
module tb_note_frame_controller;

    localparam int unsigned GW = 4;
    localparam int unsigned GH = 3;
    localparam int unsigned BS = 2;
    localparam int unsigned NB = 12;
    localparam int unsigned TC = 5;
    localparam int unsigned SS = 2;
    localparam int unsigned PD = 3;

    logic        clock, reset, start;
    logic        shiftSong, writeToScreen, loadStartAddress, loadX, loadY;
    logic        loadDefault, writeDefault, songDone, vgaPlot, busy;
    logic [15:0] gridCounter;
    logic [3:0]  boxCounter;
    logic [14:0] pixelCount;

    note_frame_controller #(
        .GRID_W(GW), .GRID_H(GH), .BOX_SIZE(BS), .NUM_BOXES(NB),
        .TICK_CYCLES(TC), .SONG_STEPS(SS), .PIPE_DEPTH(PD)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .shiftSong(shiftSong), .writeToScreen(writeToScreen),
        .loadStartAddress(loadStartAddress), .loadX(loadX), .loadY(loadY),
        .loadDefault(loadDefault), .writeDefault(writeDefault), .songDone(songDone),
        .gridCounter(gridCounter), .boxCounter(boxCounter), .pixelCount(pixelCount),
        .vgaPlot(vgaPlot), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        start;
        logic        shiftSong, writeToScreen, loadStartAddress, loadXY;
        logic        loadDefault, writeDefault, songDone, busy, vgaPlot;
        logic [15:0] grid;
        logic [3:0]  box;
        logic [14:0] pix;
        int          win;
        string       tag;
    } vec_t;

    vec_t q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t blank(string tag);
        vec_t v;
        v.start = 1'b0; v.shiftSong = 1'b0; v.writeToScreen = 1'b0;
        v.loadStartAddress = 1'b0; v.loadXY = 1'b0; v.loadDefault = 1'b0;
        v.writeDefault = 1'b0; v.songDone = 1'b0; v.busy = 1'b0; v.vgaPlot = 1'b0;
        v.grid = '0; v.box = '0; v.pix = '0; v.win = 0; v.tag = tag;
        return v;
    endfunction

    function automatic logic [44:0] packV(vec_t v);
        return {v.shiftSong, v.writeToScreen, v.loadStartAddress, v.loadXY, v.loadXY,
                v.loadDefault, v.writeDefault, v.songDone, v.busy, v.vgaPlot,
                v.grid, v.box, v.pix};
    endfunction

    function automatic logic [44:0] dutPack();
        return {shiftSong, writeToScreen, loadStartAddress, loadX, loadY,
                loadDefault, writeDefault, songDone, busy, vgaPlot,
                gridCounter, boxCounter, pixelCount};
    endfunction

    task automatic check(input string name, input logic [44:0] got, input logic [44:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Builds the expected record stream for one full song starting from IDLE
    task automatic buildSong();
        vec_t v;
        for (int k = 0; k < int'(GW * GH); k++) begin
            v = blank("default");
            v.start = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            v.loadDefault = 1'b1; v.writeDefault = 1'b1; v.busy = 1'b1;
            v.grid = {8'(k / int'(GH)), 8'(k % int'(GH))}; v.win = 1;
            q.push_back(v);
        end
        for (int k = 0; k < int'(PD); k++) begin
            v = blank("default_flush");
            v.start = 1'($urandom_range(0, 1));
            v.writeDefault = 1'b1; v.busy = 1'b1;
            v.grid = {8'(GW - 1), 8'(GH - 1)}; v.win = 1;
            q.push_back(v);
        end
        for (int k = 0; k < int'(TC); k++) begin
            v = blank("wait"); v.start = 1'($urandom_range(0, 1)); v.busy = 1'b1; v.win = 1;
            q.push_back(v);
        end
        for (int s = 1; s <= int'(SS); s++) begin
            v = blank("shift"); v.start = 1'($urandom_range(0, 1));
            v.shiftSong = 1'b1; v.busy = 1'b1; v.win = 1 + s;
            q.push_back(v);
            if (s == int'(SS)) begin
                v = blank("done"); v.start = 1'($urandom_range(0, 1));
                v.songDone = 1'b1; v.busy = 1'b1; v.win = 1 + s;
                q.push_back(v);
            end else begin
                for (int b = 1; b <= int'(NB); b++) begin
                    v = blank("box_setup"); v.start = 1'($urandom_range(0, 1));
                    v.loadStartAddress = 1'b1; v.busy = 1'b1; v.box = 4'(b); v.win = 1 + s;
                    q.push_back(v);
                    for (int i = 0; i < int'(BS * BS); i++) begin
                        v = blank("box_draw"); v.start = 1'($urandom_range(0, 1));
                        v.loadXY = 1'b1; v.writeToScreen = 1'b1; v.busy = 1'b1; v.box = 4'(b);
                        v.pix = {8'(i / int'(BS)), 7'(i % int'(BS))}; v.win = 1 + s;
                        q.push_back(v);
                    end
                end
                for (int k = 0; k < int'(PD); k++) begin
                    v = blank("box_flush"); v.start = 1'($urandom_range(0, 1));
                    v.writeToScreen = 1'b1; v.busy = 1'b1; v.box = 4'(NB);
                    v.pix = {8'(BS - 1), 7'(BS - 1)}; v.win = 1 + s;
                    q.push_back(v);
                end
                for (int k = 0; k < int'(TC); k++) begin
                    v = blank("wait"); v.start = 1'($urandom_range(0, 1));
                    v.busy = 1'b1; v.win = 1 + s;
                    q.push_back(v);
                end
            end
        end
    endtask

    initial begin
        vec_t v;
        vec_t dflt;
        int plotA, plotB, doneSeen;
        bit found;

        // Expected stream: idle, one full song, idle with start held, restart
        for (int k = 0; k < 20; k++) q.push_back(blank("idle"));
        buildSong();
        v = blank("idle_after_done"); v.start = 1'b1; q.push_back(v);
        dflt = blank("restart"); dflt.start = 1'b1; dflt.loadDefault = 1'b1;
        dflt.writeDefault = 1'b1; dflt.busy = 1'b1;
        q.push_back(dflt);
        for (int i = 0; i < q.size(); i++) begin
            v = q[i];
            v.vgaPlot = (i >= int'(PD)) ? (q[i-PD].loadDefault | q[i-PD].loadXY) : 1'b0;
            q[i] = v;
        end

        // Reset hold
        start = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check($sformatf("reset_hold%0d", k), dutPack(), 45'd0);
        end
        reset = 1'b1;

        plotA = 0; plotB = 0;
        for (int i = 0; i < q.size(); i++) begin
            start = q[i].start;
            @(posedge clock); #1;
            check($sformatf("vec%0d(%s)", i, q[i].tag), dutPack(), packV(q[i]));
            if (q[i].win == 1 && vgaPlot) plotA++;
            if (q[i].win == 2 && vgaPlot) plotB++;
        end
        checkInt("default_plot_count", plotA, int'(GW * GH));
        checkInt("box_plot_count", plotB, int'(NB * BS * BS));

        // Async reset in the middle of box 5's draw
        start = 1'b0;
        found = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clock); #1;
            if (songDone) doneSeen++;
            if (boxCounter == 4'd5 && loadX) found = 1'b1;
        end
        checkInt("reach_box5_draw", int'(found), 1);
        #3 reset = 1'b0;
        #1;
        check("async_reset_immediate", dutPack(), 45'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            if (songDone) doneSeen++;
            check($sformatf("async_reset_hold%0d", k), dutPack(), 45'd0);
        end
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (songDone) doneSeen++;
            check($sformatf("post_reset_idle%0d", k), dutPack(), 45'd0);
        end
        checkInt("no_songDone_after_abort", doneSeen, 0);

        start = 1'b1;
        @(posedge clock); #1;
        check("start_after_abort", dutPack(), packV(dflt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
